// File: rtl/ring_token_arbiter_pkg.sv
// ring_token_arbiter_pkg: arbiter state encoding and default configuration.
`default_nettype none

package ring_token_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int DEF_N        = 3;
  localparam int DEF_IDXW     = 2;
  localparam int DEF_HOLD_MAX = 15;

endpackage

`default_nettype wire

// File: rtl/ring_token_ptr.sv
// ring_token_ptr: one-hot ring pointer; loads onehot(owner) rotated left by one,
// or steps itself left by one on advance. Resets to bit 0.
`default_nettype none

module ring_token_ptr
  import ring_token_arbiter_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int IDXW = DEF_IDXW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            advance,
  input  logic            load,
  input  logic [IDXW-1:0] owner,
  output logic [N-1:0]    token
);

  logic [N-1:0] ptr_q;
  logic [N-1:0] owner_oh;

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < N; i++) begin
      owner_oh[i] = (owner == IDXW'(i));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= N'(1);
    end else if (load) begin
      ptr_q <= {owner_oh[N-2:0], owner_oh[N-1]};
    end else if (advance) begin
      ptr_q <= {ptr_q[N-2:0], ptr_q[N-1]};
    end
  end

  assign token = ptr_q;

endmodule

`default_nettype wire

// File: rtl/ring_token_arbiter.sv
// ring_token_arbiter: round-robin token arbiter with grant/done handshake and a
// dead cycle between grants. Optional forced release under RING_ARB_TIMEOUT_EN.
`default_nettype none

module ring_token_arbiter
  import ring_token_arbiter_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int IDXW     = DEF_IDXW,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    done,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] owner,
  output logic            busy,
  output logic [N-1:0]    token,
  output logic            timeout
);

  if (N < 2 || (2 ** IDXW) < N || HOLD_MAX < 1) begin : g_param_check
    $error("ring_token_arbiter: illegal N/IDXW/HOLD_MAX combination");
  end

  arb_state_t      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] winner;
  logic [N-1:0]    winner_oh;
  logic            found;
  logic            done_owner;
  logic            expire;
  logic            release_now;

  // Lower offsets from the token are visited last, so the nearest request wins.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    winner_oh = '0;
    for (int off = N - 1; off >= 0; off--) begin
      for (int i = 0; i < N; i++) begin
        if (token[i] && req[(i + off) % N]) begin
          found                   = 1'b1;
          winner                  = IDXW'((i + off) % N);
          winner_oh               = '0;
          winner_oh[(i + off) % N] = 1'b1;
        end
      end
    end
  end

  // grant_q is onehot(owner) while in GRANT, so this filters non-owner done bits.
  assign done_owner = |(done & grant_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = winner_oh;
          owner_d = winner;
        end
      end
      GRANT: begin
        if (done_owner || expire) begin
          release_now = 1'b1;
          state_d     = GAP;
          grant_d     = '0;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
    end
  end

  ring_token_ptr #(
    .N    (N),
    .IDXW (IDXW)
  ) u_token_ptr (
    .clock   (clock),
    .reset   (reset),
    .advance (1'b0),
    .load    (release_now),
    .owner   (owner_q),
    .token   (token)
  );

`ifdef RING_ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] hold_q;
  logic          timeout_q;

  // hold_q counts completed GRANT cycles, so expiry lands on the HOLD_MAX-th one.
  assign expire = (state_q == GRANT) && (hold_q == CW'(HOLD_MAX - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= release_now && expire && !done_owner;
      if (state_q != GRANT) begin
        hold_q <= '0;
      end else begin
        hold_q <= hold_q + CW'(1);
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = |grant_q;

endmodule

`default_nettype wire

// File: tb/tb_ring_token_arbiter.sv
// tb_ring_token_arbiter: directed checks of arbitration order, release, gap,
// async reset and hold timeout (RING_ARB_TIMEOUT_EN aware).
`default_nettype none

module tb_ring_token_arbiter;

  logic       clock;
  logic       reset;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic [2:0] token;
  logic       timeout;

  int checks;
  int errors;

  ring_token_arbiter #(
    .N        (3),
    .IDXW     (2),
    .HOLD_MAX (15)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .token   (token),
    .timeout (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 3'b111;
    done  = 3'b000;
    repeat (3) step();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got %b want 000", grant); end
    checks++; if (token !== 3'b001) begin errors++; $display("FAIL reset_token got %b want 001", token); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    reset = 1'b1;
    step();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL first_grant got %b want 001", grant); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL first_owner got %0d want 0", owner); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got %b want 1", busy); end
  endtask

  task automatic test_rotation();
    done = 3'b001;
    step();
    done = 3'b000;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rel_edge_grant got %b want 000", grant); end
    checks++; if (token !== 3'b010) begin errors++; $display("FAIL rel_token got %b want 010", token); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rel_busy got %b want 0", busy); end
    step();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL gap_grant got %b want 000", grant); end
    step();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL rot1_grant got %b want 010", grant); end
    checks++; if (token !== 3'b010) begin errors++; $display("FAIL rot1_token got %b want 010", token); end
    done = 3'b010;
    step();
    done = 3'b000;
    step();
    step();
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL rot2_grant got %b want 100", grant); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL rot2_owner got %0d want 2", owner); end
    done = 3'b100;
    step();
    done = 3'b000;
    checks++; if (token !== 3'b001) begin errors++; $display("FAIL wrap_token got %b want 001", token); end
    step();
    step();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL wrap_grant got %b want 001", grant); end
  endtask

  task automatic test_wrap_search();
    req  = 3'b010;
    done = 3'b001;
    step();
    done = 3'b000;
    step();
    step();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL ws_setup_grant got %b want 010", grant); end
    req  = 3'b011;
    done = 3'b010;
    step();
    done = 3'b000;
    checks++; if (token !== 3'b100) begin errors++; $display("FAIL ws_token got %b want 100", token); end
    step();
    step();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL ws_grant got %b want 001", grant); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL ws_owner got %0d want 0", owner); end
  endtask

  task automatic test_done_filter();
    req  = 3'b010;
    done = 3'b001;
    step();
    done = 3'b000;
    step();
    step();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL df_setup_grant got %b want 010", grant); end
    done = 3'b101;
    step();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL df_ignore1 got %b want 010", grant); end
    done = 3'b000;
    step();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL df_ignore2 got %b want 010", grant); end
    done = 3'b010;
    step();
    done = 3'b000;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL df_release got %b want 000", grant); end
    checks++; if (token !== 3'b100) begin errors++; $display("FAIL df_token got %b want 100", token); end
  endtask

  task automatic test_async_reset();
    step();
    step();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL ar_setup_grant got %b want 010", grant); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL ar_grant got %b want 000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b want 0", busy); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    req   = 3'b000;
    step();
    checks++; if (token !== 3'b001) begin errors++; $display("FAIL ar_token got %b want 001", token); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL ar_idle_grant got %b want 000", grant); end
  endtask

  task automatic test_timeout();
    int   held;
    logic seen_to;
    logic dropped;
    held    = 0;
    seen_to = 1'b0;
    dropped = 1'b0;
    req = 3'b001;
    step();
    req = 3'b000;
    if (grant === 3'b001) held = 1;
    for (int i = 0; i < 120 && !dropped; i++) begin
      step();
      if (grant === 3'b001) begin
        held++;
        if (timeout !== 1'b0) seen_to = 1'b1;
      end else begin
        dropped = 1'b1;
      end
    end
    checks++; if (seen_to !== 1'b0) begin errors++; $display("FAIL to_early_pulse got %b want 0", seen_to); end
`ifdef RING_ARB_TIMEOUT_EN
    checks++; if (held != 15) begin errors++; $display("FAIL to_hold_cycles got %0d want 15", held); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got %b want 1", timeout); end
    checks++; if (token !== 3'b010) begin errors++; $display("FAIL to_token got %b want 010", token); end
    step();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_end got %b want 0", timeout); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL to_gap_grant got %b want 000", grant); end
`else
    checks++; if (held <= 100) begin errors++; $display("FAIL hold_cycles got %0d want >100", held); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL hold_timeout got %b want 0", timeout); end
    checks++; if (token !== 3'b001) begin errors++; $display("FAIL hold_token got %b want 001", token); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    req    = 3'b000;
    done   = 3'b000;
    test_reset();
    test_rotation();
    test_wrap_search();
    test_done_filter();
    test_async_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
